mul_256b_ctrl: RTL and testbench
================================

MUL_256B_CTRL -- requirements
Module: mul_256b_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk (rising edge) and rst_n.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mul_vld_i  input  1  request; caller holds it high until mul_fin_o.
REQ-005 mul_a_i  input  256  operand A, unsigned.
REQ-006 mul_b_i  input  256  operand B, unsigned.
REQ-007 mul_fin_o  output  1  one-cycle pulse; mul_r_o is valid in that cycle.
REQ-008 mul_r_o  output  512  product A*B.
REQ-009 sub_vld_o  output  1  request to the external 128x128 multiplier, held high until sub_fin_i.
REQ-010 sub_a_o, sub_b_o  output  128 each  sub-operands, stable while sub_vld_o=1.
REQ-011 sub_fin_i  input  1  one-cycle completion pulse from the 128x128 multiplier.
REQ-012 sub_r_i  input  256  sub-product; sampled only when sub_fin_i=1 and sub_vld_o=1.

Function
REQ-013 The block SHALL compute A*B as four 128x128 partial products, issued in this fixed order:
- k=0: (A[127:0], B[127:0]), shift 0
- k=1: (A[127:0], B[255:128]), shift 128
- k=2: (A[255:128], B[127:0]), shift 128
- k=3: (A[255:128], B[255:128]), shift 256
REQ-014 State machine SHALL have the states IDLE, ISSUE, GAP and DONE.
REQ-015 IDLE:
- mul_vld_i=1 -> latch A and B, clear the 512-bit accumulator, k=0, go to ISSUE.
- otherwise stay in IDLE.
REQ-016 ISSUE:
- sub_vld_o=1 and sub_a_o/sub_b_o are driven for the current k.
- On sub_fin_i=1: acc <= acc + (sub_r_i << shift_k).
- If k<3: k <= k+1 and go to GAP; if k=3: go to DONE.
REQ-017 GAP SHALL last exactly one cycle with sub_vld_o=0, then return to ISSUE.
REQ-018 DONE SHALL last exactly one cycle:
- mul_fin_o=1 and mul_r_o=acc.
- Next state is IDLE unconditionally, even if mul_vld_i is still 1.
REQ-019 mul_r_o SHALL hold its last value until the next DONE.
REQ-020 Accumulation SHALL be full 512-bit unsigned; since A*B < 2^512, no carry is ever lost.
REQ-021 Latency from the IDLE capture edge to mul_fin_o = sum of the four sub-latencies (vld-high to fin, in cycles) + 3 GAP cycles + 1 cycle; the block SHALL add no further cycles.
REQ-022 Boundary conditions:
- Changes on mul_a_i/mul_b_i after capture SHALL have no effect.
- sub_fin_i while sub_vld_o=0 SHALL be ignored.
- mul_vld_i dropping mid-operation SHALL NOT abort the operation.
- sub_fin_i in the first cycle of ISSUE (zero-wait responder) SHALL be accepted.

Reset
REQ-023 While rst_n=0, all of the following SHALL be 0 asynchronously: state (IDLE), k, accumulator, latched operands, sub_vld_o, sub_a_o, sub_b_o, mul_fin_o and mul_r_o.
REQ-024 Reset mid-operation SHALL abandon the operation with no mul_fin_o pulse; the first request after release SHALL complete correctly.

Structure
REQ-025 A shared package SHALL hold:
- the state encoding (IDLE, ISSUE, GAP, DONE);
- the width constants W_HALF=128, W_OP=256, W_PROD=512;
- the per-k shift table.
REQ-026 The block SHALL NOT instantiate a multiplier; the natural sub-module is mul_ko_128b, connected to the sub_* port in a top-level wrapper.

Verification
REQ-027 The bench SHALL cover these directed scenarios, with sub_* driven by a behavioural 128x128 model of configurable latency:
- A=1, B=1 -> mul_r_o=1, exactly one mul_fin_o pulse.
- A=B=2^256-1 -> mul_r_o=2^512-2^257+1.
- A={128'h1,128'h2}, B={128'h3,128'h4} -> sub requests (2,4),(2,3),(1,4),(1,3) in order; mul_r_o=3*2^256+10*2^128+8; each sub_vld_o gap exactly 1 cycle.
- Model latency 0 and latency 5 with the same operands -> identical result; fin cycle equals the REQ-021 formula.
- rst_n pulsed low during k=2 -> all outputs 0, no fin; a new request A=5, B=7 -> 35.
- 1000 random operand pairs, with mul_a_i/mul_b_i randomised every cycle after capture -> mul_r_o equals the captured A*B.

Source files
------------

// File: rtl/mul_256b_ctrl_pkg.sv
// Shared definitions for the 256x256 multiply controller: FSM encoding,
// operand/product widths and the partial-product issue table.
package mul_256b_ctrl_pkg;

    localparam int W_HALF = 128;
    localparam int W_OP   = 256;
    localparam int W_PROD = 512;
    localparam int N_PP   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] pp_idx_t;

    // Left shift applied to partial product k before accumulation.
    localparam int unsigned PP_SHIFT [N_PP] = '{0, W_HALF, W_HALF, 2 * W_HALF};

    // Bit k set means partial product k uses the upper half of that operand.
    localparam logic [N_PP-1:0] PP_A_HI = 4'b1100;
    localparam logic [N_PP-1:0] PP_B_HI = 4'b1010;

    function automatic logic [W_HALF-1:0] op_half(input logic [W_OP-1:0] op,
                                                  input logic            hi);
        return hi ? op[W_OP-1:W_HALF] : op[W_HALF-1:0];
    endfunction

    function automatic logic [W_PROD-1:0] pp_align(input logic [2*W_HALF-1:0] pp,
                                                   input pp_idx_t             k);
        logic [W_PROD-1:0] ext;
        ext = {{(W_PROD - 2 * W_HALF){1'b0}}, pp};
        return ext << PP_SHIFT[k];
    endfunction

endpackage

// File: rtl/mul_256b_ctrl_pp.sv
// Partial-product steering: picks the operand halves for index k and aligns
// the returned 256-bit sub-product to its weight in the 512-bit result.
module mul_256b_ctrl_pp
    import mul_256b_ctrl_pkg::*;
(
    input  logic [W_OP-1:0]     a,
    input  logic [W_OP-1:0]     b,
    input  pp_idx_t             k,
    input  logic [2*W_HALF-1:0] pp,
    output logic [W_HALF-1:0]   a_half,
    output logic [W_HALF-1:0]   b_half,
    output logic [W_PROD-1:0]   pp_aligned
);

    // Operand half selection and product alignment for the current index.
    always_comb begin
        a_half     = op_half(a, PP_A_HI[k]);
        b_half     = op_half(b, PP_B_HI[k]);
        pp_aligned = pp_align(pp, k);
    end

endmodule

// File: rtl/mul_256b_ctrl.sv
// 256x256 unsigned multiply controller. Splits the operation into four
// 128x128 partial products served by an external multiplier over the sub_*
// handshake, and accumulates them into a 512-bit product.
module mul_256b_ctrl
    import mul_256b_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mul_vld_i,
    input  logic [W_OP-1:0]     mul_a_i,
    input  logic [W_OP-1:0]     mul_b_i,
    output logic                mul_fin_o,
    output logic [W_PROD-1:0]   mul_r_o,
    output logic                sub_vld_o,
    output logic [W_HALF-1:0]   sub_a_o,
    output logic [W_HALF-1:0]   sub_b_o,
    input  logic                sub_fin_i,
    input  logic [2*W_HALF-1:0] sub_r_i
);

    state_t            state;
    pp_idx_t           k;
    logic [W_OP-1:0]   a_q;
    logic [W_OP-1:0]   b_q;
    logic [W_PROD-1:0] acc;

    logic [W_HALF-1:0] nxt_a_half;
    logic [W_HALF-1:0] nxt_b_half;
    logic [W_PROD-1:0] pp_aligned;
    logic [W_PROD-1:0] acc_nxt;
    logic              sub_take;

    mul_256b_ctrl_pp u_pp (
        .a          (a_q),
        .b          (b_q),
        .k          (k),
        .pp         (sub_r_i),
        .a_half     (nxt_a_half),
        .b_half     (nxt_b_half),
        .pp_aligned (pp_aligned)
    );

    // A completion only counts while a request is actually outstanding.
    assign sub_take = sub_vld_o & sub_fin_i;
    assign acc_nxt  = acc + pp_aligned;

    // Controller FSM; all handshake outputs and the result are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            sub_vld_o <= 1'b0;
            sub_a_o   <= '0;
            sub_b_o   <= '0;
            mul_fin_o <= 1'b0;
            mul_r_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mul_fin_o <= 1'b0;
                    if (mul_vld_i) begin
                        a_q       <= mul_a_i;
                        b_q       <= mul_b_i;
                        acc       <= '0;
                        k         <= '0;
                        // First request goes out straight from the inputs so
                        // ISSUE starts on the very next cycle.
                        sub_vld_o <= 1'b1;
                        sub_a_o   <= op_half(mul_a_i, PP_A_HI[0]);
                        sub_b_o   <= op_half(mul_b_i, PP_B_HI[0]);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sub_take) begin
                        acc       <= acc_nxt;
                        sub_vld_o <= 1'b0;
                        if (k == pp_idx_t'(N_PP - 1)) begin
                            mul_fin_o <= 1'b1;
                            mul_r_o   <= acc_nxt;
                            state     <= DONE;
                        end else begin
                            k     <= k + 2'd1;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    sub_vld_o <= 1'b1;
                    sub_a_o   <= nxt_a_half;
                    sub_b_o   <= nxt_b_half;
                    state     <= ISSUE;
                end
                DONE: begin
                    mul_fin_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_256b_ctrl.sv
// Directed bench for mul_256b_ctrl with a behavioural 128x128 responder of
// configurable wait-state count.
module tb_mul_256b_ctrl;

    logic         clk;
    logic         rst_n;
    logic         mul_vld_i;
    logic [255:0] mul_a_i;
    logic [255:0] mul_b_i;
    logic         mul_fin_o;
    logic [511:0] mul_r_o;
    logic         sub_vld_o;
    logic [127:0] sub_a_o;
    logic [127:0] sub_b_o;
    logic         sub_fin_i;
    logic [255:0] sub_r_i;

    mul_256b_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_vld_i (mul_vld_i),
        .mul_a_i   (mul_a_i),
        .mul_b_i   (mul_b_i),
        .mul_fin_o (mul_fin_o),
        .mul_r_o   (mul_r_o),
        .sub_vld_o (sub_vld_o),
        .sub_a_o   (sub_a_o),
        .sub_b_o   (sub_b_o),
        .sub_fin_i (sub_fin_i),
        .sub_r_i   (sub_r_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: lat = wait cycles before fin (0 = fin in first vld cycle).
    int unsigned lat;
    int unsigned wait_cnt;
    bit          stray;
    logic [255:0] prod;

    assign prod      = sub_a_o * sub_b_o;
    assign sub_fin_i = (sub_vld_o && (wait_cnt == lat)) || (!sub_vld_o && stray);
    assign sub_r_i   = sub_fin_i ? prod : {8{32'hDEADBEEF}};

    always @(posedge clk) begin
        if (!sub_vld_o || sub_fin_i) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    // Monitor of the sub handshake and result pulses, sampled mid-cycle.
    int           ncyc;
    bit           prev_vld;
    int           mfin_cnt;
    logic [127:0] ra_q[$];
    logic [127:0] rb_q[$];
    int           fin_q[$];
    int           rise_q[$];

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (sub_vld_o && !prev_vld) rise_q.push_back(ncyc);
        if (sub_vld_o && sub_fin_i) begin
            ra_q.push_back(sub_a_o);
            rb_q.push_back(sub_b_o);
            fin_q.push_back(ncyc);
        end
        if (mul_fin_o) mfin_cnt <= mfin_cnt + 1;
        prev_vld <= sub_vld_o;
    end

    int checks;
    int passes;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_mon();
        ra_q.delete();
        rb_q.delete();
        fin_q.delete();
        rise_q.delete();
    endtask

    // One operation. cyc = index of the cycle carrying mul_fin_o, where
    // cycle 1 is the one right after the capture edge.
    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          input int unsigned l, input bit scramble, input bit drop,
                          output logic [511:0] res, output int cyc);
        bit done;
        lat = l;
        @(negedge clk);
        mul_a_i   = a;
        mul_b_i   = b;
        mul_vld_i = 1'b1;
        @(posedge clk);
        cyc  = 0;
        done = 0;
        res  = '0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (drop) mul_vld_i = 1'b0;
            if (mul_fin_o) begin
                done      = 1;
                res       = mul_r_o;
                mul_vld_i = 1'b0;
            end else if (scramble) begin
                mul_a_i = rand256();
                mul_b_i = rand256();
            end
        end
        mul_vld_i = 1'b0;
        chk("op_completed", 512'(done), 512'd1);
    endtask

    logic [511:0] res;
    logic [511:0] res0;
    int           cyc;
    logic [255:0] ra;
    logic [255:0] rb;
    logic [255:0] all1;

    initial begin
        rst_n     = 1'b1;
        mul_vld_i = 1'b0;
        mul_a_i   = '0;
        mul_b_i   = '0;
        lat       = 0;
        stray     = 0;
        checks    = 0;
        passes    = 0;
        mfin_cnt  = 0;
        ncyc      = 0;
        all1      = '1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sub_vld", 512'(sub_vld_o), 512'd0);
        chk("rst_mul_fin", 512'(mul_fin_o), 512'd0);
        chk("rst_mul_r", mul_r_o, 512'd0);
        chk("rst_sub_a", 512'(sub_a_o), 512'd0);
        chk("rst_sub_b", 512'(sub_b_o), 512'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mfin_cnt = 0;

        // 1 x 1, single pulse, result held afterwards
        run_op(256'd1, 256'd1, 1, 0, 0, res, cyc);
        chk("one_x_one", res, 512'd1);
        repeat (3) @(negedge clk);
        chk("one_x_one_pulses", 512'(mfin_cnt), 512'd1);
        chk("one_x_one_hold", mul_r_o, 512'd1);

        // all-ones operands: 2^512 - 2^257 + 1
        run_op(all1, all1, 2, 0, 0, res, cyc);
        chk("max_x_max", res, {{255{1'b1}}, 1'b0, 256'd1});

        // Ordering, gaps, stray completions, early drop of mul_vld_i, zero wait
        stray = 1;
        clear_mon();
        run_op({128'h1, 128'h2}, {128'h3, 128'h4}, 0, 0, 1, res0, cyc);
        chk("split_result", res0, (512'd3 << 256) + (512'd10 << 128) + 512'd8);
        chk("split_lat0_cycles", 512'(cyc), 512'd8);
        chk("split_req_count", 512'(fin_q.size()), 512'd4);
        if (fin_q.size() == 4) begin
            chk("req0_a", 512'(ra_q[0]), 512'd2);
            chk("req0_b", 512'(rb_q[0]), 512'd4);
            chk("req1_a", 512'(ra_q[1]), 512'd2);
            chk("req1_b", 512'(rb_q[1]), 512'd3);
            chk("req2_a", 512'(ra_q[2]), 512'd1);
            chk("req2_b", 512'(rb_q[2]), 512'd4);
            chk("req3_a", 512'(ra_q[3]), 512'd1);
            chk("req3_b", 512'(rb_q[3]), 512'd3);
        end
        chk("split_rise_count", 512'(rise_q.size()), 512'd4);
        if (rise_q.size() == 4 && fin_q.size() == 4) begin
            for (int j = 1; j < 4; j++)
                chk("split_gap_len", 512'(rise_q[j] - fin_q[j-1] - 1), 512'd1);
        end
        stray = 0;

        // Same operands with five wait states: 4*6 + 3 + 1 = 28
        run_op({128'h1, 128'h2}, {128'h3, 128'h4}, 5, 0, 0, res, cyc);
        chk("lat5_result", res, res0);
        chk("lat5_cycles", 512'(cyc), 512'd28);

        // Reset while partial product k=2 is outstanding
        lat = 2;
        clear_mon();
        @(negedge clk);
        mfin_cnt  = 0;
        mul_a_i   = rand256();
        mul_b_i   = rand256();
        mul_vld_i = 1'b1;
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (sub_vld_o && fin_q.size() == 2) hit = 1;
            end
            chk("rst_reach_k2", 512'(hit), 512'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sub_vld", 512'(sub_vld_o), 512'd0);
        chk("midrst_sub_a", 512'(sub_a_o), 512'd0);
        chk("midrst_sub_b", 512'(sub_b_o), 512'd0);
        chk("midrst_mul_fin", 512'(mul_fin_o), 512'd0);
        chk("midrst_mul_r", mul_r_o, 512'd0);
        repeat (3) @(negedge clk);
        mul_vld_i = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_fin", 512'(mfin_cnt), 512'd0);
        run_op(256'd5, 256'd7, 1, 0, 0, res, cyc);
        chk("after_rst_5x7", res, 512'd35);

        // Random operands, inputs scrambled after capture, stray fins on
        stray = 1;
        for (int n = 0; n < 1000; n++) begin
            ra = rand256();
            rb = rand256();
            run_op(ra, rb, $urandom_range(0, 3), 1, 0, res, cyc);
            chk("rand_product", res, 512'(ra) * 512'(rb));
        end
        stray = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
